// File: rtl/piso_ser_pkg.sv
// Shared definitions for the piso_ser serializer.
//   state_e   : FSM state encoding (IDLE, SHIFT, DONE), 2 bits
//   cnt_width : width of the bit-index counter for a given word length
package piso_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_ser_cnt.sv
// Bit-index counter for piso_ser.
//   ck_i  : clock, rising edge
//   r_i   : asynchronous active-high reset
//   clr_i : synchronous clear to 0 (wins over en_i)
//   en_i  : increment by one
//   cnt_o : current index
//   tc_o  : terminal count, high when cnt_o == WIDTH-1
module piso_ser_cnt #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
) (
    input  logic          ck_i,
    input  logic          r_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge ck_i or posedge r_i) begin
        if (r_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_ser.sv
// Parallel-in, serial-out serializer with load/busy/done framing.
//   ck_i   : clock, rising edge
//   r_i    : asynchronous active-high reset
//   ld_i   : load request, honoured in IDLE and DONE only
//   din_i  : parallel word captured on an accepted load
//   en_i   : shift enable, honoured in SHIFT only
//   so_o   : serial data out (output end of the shift register)
//   busy_o : high while a word is being shifted
//   done_o : one-cycle pulse after the last bit
//   cnt_o  : index of the bit currently on so_o
module piso_ser
    import piso_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         ck_i,
    input  logic                         r_i,
    input  logic                         ld_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         en_i,
    output logic                         so_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [cnt_width(WIDTH)-1:0]  cnt_o
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ld_acc;
    logic             shift_go;
    logic             tc;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        ld_acc   = 1'b0;
        shift_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_i) begin
                    ld_acc  = 1'b1;
                    sr_d    = din_i;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (en_i) begin
                    shift_go = 1'b1;
                    // Zero-fill so so_o reads 0 once the word has drained.
                    sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, sr_q[WIDTH-1:1]};
                    if (tc) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (ld_i) begin
                    ld_acc  = 1'b1;
                    sr_d    = din_i;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge ck_i or posedge r_i) begin
        if (r_i) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The final shift clears the index so it is 0 again in DONE.
    piso_ser_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .ck_i  (ck_i),
        .r_i   (r_i),
        .clr_i (ld_acc | (shift_go & tc)),
        .en_i  (shift_go),
        .cnt_o (cnt_o),
        .tc_o  (tc)
    );

    assign so_o   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_piso_ser.sv
module tb_piso_ser;

    typedef struct {
        logic       so_m;
        logic       so_l;
        logic [2:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    logic       ck_i;
    logic       r_i;
    logic       ld_i;
    logic [7:0] din_i;
    logic       en_i;
    logic       so_m, busy_m, done_m;
    logic       so_l, busy_l, done_l;
    logic [2:0] cnt_m, cnt_l;
    logic       ds_q;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];

    // reference model state
    int         m_state = 0;
    logic [7:0] m_word  = '0;
    int         m_idx   = 0;
    logic       prev_so = 1'b0;

    piso_ser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .ck_i(ck_i), .r_i(r_i), .ld_i(ld_i), .din_i(din_i), .en_i(en_i),
        .so_o(so_m), .busy_o(busy_m), .done_o(done_m), .cnt_o(cnt_m)
    );

    piso_ser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .ck_i(ck_i), .r_i(r_i), .ld_i(ld_i), .din_i(din_i), .en_i(en_i),
        .so_o(so_l), .busy_o(busy_l), .done_o(done_l), .cnt_o(cnt_l)
    );

    // downstream dffrs stage fed by the MSB-first serializer
    always_ff @(posedge ck_i or posedge r_i) begin
        if (r_i) ds_q <= 1'b0;
        else     ds_q <= so_m;
    end

    initial ck_i = 1'b0;
    always #5 ck_i = ~ck_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic ld, input logic en, input logic [7:0] din);
        exp_t e;
        if (r) begin
            m_state = 0;
            m_idx   = 0;
        end else begin
            case (m_state)
                0: if (ld) begin m_word = din; m_idx = 0; m_state = 1; end
                1: if (en) begin
                       if (m_idx == 7) begin m_idx = 0; m_state = 2; end
                       else m_idx++;
                   end
                default: begin
                    if (ld) begin m_word = din; m_idx = 0; m_state = 1; end
                    else m_state = 0;
                end
            endcase
        end
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        e.cnt  = (m_state == 1) ? 3'(m_idx) : 3'd0;
        e.so_m = (m_state == 1) ? m_word[7 - m_idx] : 1'b0;
        e.so_l = (m_state == 1) ? m_word[m_idx] : 1'b0;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive inputs, push expectation, sample after the edge.
    task automatic cyc(input logic r, input logic ld, input logic en, input logic [7:0] din);
        exp_t e;
        r_i = r; ld_i = ld; en_i = en; din_i = din;
        model_step(r, ld, en, din);
        if (r) begin
            #1;
            chk("rst_now_so",   {so_m, so_l}, 2'b00);
            chk("rst_now_busy", {busy_m, busy_l}, 2'b00);
            chk("rst_now_done", {done_m, done_l}, 2'b00);
            chk("rst_now_cnt",  {cnt_m, cnt_l}, 6'd0);
        end
        @(posedge ck_i);
        #1;
        e = exp_q.pop_front();
        chk("so_msb",  so_m,   e.so_m);
        chk("so_lsb",  so_l,   e.so_l);
        chk("cnt_msb", cnt_m,  e.cnt);
        chk("cnt_lsb", cnt_l,  e.cnt);
        chk("busy",    {busy_m, busy_l}, {e.busy, e.busy});
        chk("done",    {done_m, done_l}, {e.done, e.done});
        chk("dffrs",   ds_q, r ? 1'b0 : prev_so);
        prev_so = e.so_m;
    endtask

    initial begin
        r_i = 1'b1; ld_i = 1'b0; en_i = 1'b0; din_i = '0;

        // reset overrides LD/EN
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("rst_so_const", so_m, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // A5, both orders, EN held high
        cyc(1'b0, 1'b1, 1'b1, 8'hA5);
        repeat (8) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("a5_done_cycle8", done_m, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // C3 with a 3-cycle stall after bit 2
        cyc(1'b0, 1'b1, 1'b1, 8'hC3);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("c3_stall_so",  so_m, 1'b0);
        chk("c3_stall_cnt", cnt_m, 3'd2);
        repeat (6) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("c3_done_cycle11", done_m, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // FF with LD ignored in flight, then back-to-back 81 from DONE
        cyc(1'b0, 1'b1, 1'b1, 8'hFF);
        repeat (8) cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("ff_done", done_m, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'h81);
        chk("b2b_so_first", so_m, 1'b1);
        repeat (8) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("b2b_done", done_m, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // F0 aborted after bit 4, then 0F
        cyc(1'b0, 1'b1, 1'b1, 8'hF0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("abort_no_done", done_m, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h0F);
        repeat (9) cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                8'($urandom));
        end

        if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_ser.md
# piso_ser

Parallel-in, serial-out serializer that loads a WIDTH-bit word and shifts it out one bit per enabled clock on SO. It sits directly upstream of the dffrs flip-flop stage: SO drives the downstream D input, and that stage captures each bit on the same CK edge that advances the serializer. A load/busy/done handshake frames each word for the controlling logic.

## Interface
- WIDTH, 8, word length in bits; legal range ≥ 2
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first
- CK  input  1  clock; all state changes on the rising edge
- R  input  1  reset, asynchronous, active-high
- LD  input  1  load request; sampled only in IDLE and DONE
- DIN  input  WIDTH  parallel word, captured on an accepted LD
- EN  input  1  shift enable; sampled only in SHIFT
- SO  output  1  serial data out; current bit of the word
- BUSY  output  1  high while a word is being shifted
- DONE  output  1  one-cycle pulse after the last bit has been shifted
- CNT  output  $clog2(WIDTH)  index of the bit currently on SO

## Operation
- Reset (R=1, asynchronous): state=IDLE, shift register=0, SO=0, BUSY=0, DONE=0, CNT=0. R held high overrides LD and EN. Deassertion is not synchronized inside the block.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - LD=1 at an edge: shift register ← DIN, CNT ← 0, go to SHIFT.
  - LD=0: hold.
- SHIFT: BUSY=1.
  - EN=1 at an edge: shift one position toward the output end, fill with 0, CNT ← CNT+1.
  - EN=0: hold all state.
  - EN=1 with CNT==WIDTH-1: final shift, CNT ← 0, go to DONE.
- DONE: DONE=1 and BUSY=0 for exactly one cycle.
  - LD=1: load DIN, go to SHIFT (back-to-back word, no idle gap).
  - LD=0: go to IDLE.
- LD in SHIFT is ignored; the word in flight is never corrupted.
- SO is the output-end bit of the shift register: bit WIDTH-1 if MSB_FIRST, else bit 0. Zero-fill makes SO=0 in IDLE and DONE.
- CNT wraps only through the SHIFT→DONE transition and never exceeds WIDTH-1.
- R asserted mid-word aborts the word immediately; no DONE pulse is produced.

## Timing
- All outputs are registered or decoded from registers only; no combinational path from any input to any output.
- LD accepted at edge t: BUSY=1 and bit 0 of the shift order is on SO from just after t.
- With EN held high, bit k is on SO during cycle t+k, for k = 0..WIDTH-1. The downstream flop captures bit k at edge t+k+1.
- DONE=1 during cycle t+WIDTH; BUSY falls at the same edge.
- Each EN=0 cycle in SHIFT stretches the word by one cycle and leaves SO stable.
- Minimum word period is WIDTH+1 cycles, via the DONE-state reload.

## Structure
- Shared header piso_defs.vh holds:
  - the state encodings for IDLE, SHIFT and DONE (2-bit localparams)
  - the CNT width function
- Natural sub-module: piso_cnt, a bit counter with clear, enable and terminal-count output (CNT==WIDTH-1), reset by R.
- The FSM and the shift register stay in piso_ser.

## Test plan
Use WIDTH=8 unless noted.
- Reset: R=1 with LD=1, DIN=8'hFF and EN=1 → SO=0, BUSY=0, DONE=0, CNT=0 throughout.
- MSB_FIRST=1, DIN=8'hA5, LD pulse, EN=1:
  - SO over cycles 0..7 = 1,0,1,0,0,1,0,1
  - CNT = 0..7
  - DONE=1 only in cycle 8, BUSY=1 in cycles 0..7
  - a downstream dffrs reproduces the same sequence one cycle later
- MSB_FIRST=0, DIN=8'hA5 → SO = 1,0,1,0,0,1,0,1 (LSB first); DONE in cycle 8.
- DIN=8'hC3 with EN low for 3 cycles after bit 2:
  - SO holds the bit-2 value (0) and CNT holds 2 during the stall
  - DONE lands in cycle 11
- LD=1 asserted during SHIFT with DIN=8'h00 → the word in flight (8'hFF) is unaffected. Then in the DONE cycle, LD=1 with DIN=8'h81 → the next word starts: SO=1 in cycle 9, DONE again in cycle 17.
- R pulsed after bit 4 of 8'hF0:
  - SO=0, BUSY=0, CNT=0 immediately, with no DONE pulse
  - after R falls, LD with 8'h0F shifts out correctly
